// File: rtl/fft_sram_arbiter_pkg.sv
// Shared constants and phase encoding for the FFT SRAM arbiter.
package fft_arb_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREQ   = 3;

    localparam int REQ_HOST = 0;
    localparam int REQ_FFT  = 1;
    localparam int REQ_WB   = 2;

    typedef enum logic [1:0] {
        HOST  = 2'd0,
        DRAIN = 2'd1,
        FFT   = 2'd2
    } phase_e;

endpackage

// File: rtl/fft_sram_arbiter_if.sv
// Requester bus, phase control and SRAM port bundle for fft_sram_arbiter.
// The lock signal exists only when FFT_ARB_LOCK_EN is defined.
interface fft_sram_arbiter_if #(
    parameter int ADDR_W = fft_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = fft_arb_pkg::DEF_DATA_W,
    parameter int NREQ   = fft_arb_pkg::DEF_NREQ
);
    logic                     start;
    logic                     fft_done;
    logic                     busy;
`ifdef FFT_ARB_LOCK_EN
    logic                     lock;
`endif
    logic [NREQ-1:0]          req;
    logic [NREQ-1:0]          we;
    logic [NREQ*ADDR_W-1:0]   addr;
    logic [NREQ*DATA_W-1:0]   wdata;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          rvalid;
    logic [DATA_W-1:0]        rdata;
    logic                     f_wren;
    logic                     f_rden;
    logic [ADDR_W-1:0]        f_address;
    logic [DATA_W-1:0]        f_data;
    logic [DATA_W-1:0]        f_q;

    modport master (
`ifdef FFT_ARB_LOCK_EN
        output lock,
`endif
        output start, fft_done, req, we, addr, wdata, f_q,
        input  busy, gnt, rvalid, rdata, f_wren, f_rden, f_address, f_data
    );

    modport slave (
`ifdef FFT_ARB_LOCK_EN
        input  lock,
`endif
        input  start, fft_done, req, we, addr, wdata, f_q,
        output busy, gnt, rvalid, rdata, f_wren, f_rden, f_address, f_data
    );

endinterface

// File: rtl/fft_sram_arbiter_rr_picker.sv
// Two-way round-robin pick: on contention the side not served last wins.
module fft_rr_picker (
    input  logic [1:0] req_i,
    input  logic       lastHi_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = lastHi_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/fft_sram_arbiter.sv
// Phase-based SRAM arbiter: host owns the SRAM in HOST, FFT engine and writeback
// share it round-robin in FFT. Optional owner lock under FFT_ARB_LOCK_EN.
module fft_sram_arbiter
    import fft_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREQ   = DEF_NREQ
) (
    input  logic               clk,
    input  logic               rst,
    fft_sram_arbiter_if.slave  bus
);

    phase_e            state_q;
    logic              busy_q;
    logic              lastWb_q;
    logic [NREQ-1:0]   rvalid_q;
`ifdef FFT_ARB_LOCK_EN
    logic [NREQ-1:0]   ownerMask_q;
`endif

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   reqElig;
    logic [1:0]        pickGnt;
    logic [NREQ-1:0]   gnt;
    logic [ADDR_W-1:0] muxAddr;
    logic [DATA_W-1:0] muxData;
    logic              muxWe;
    logic              muxRe;

    always_comb begin
        eligible = '0;
        case (state_q)
            HOST: eligible[REQ_HOST] = 1'b1;
            FFT: begin
                eligible[REQ_FFT] = 1'b1;
                eligible[REQ_WB]  = 1'b1;
            end
            default: eligible = '0;
        endcase
`ifdef FFT_ARB_LOCK_EN
        if (|ownerMask_q) begin
            eligible = eligible & ownerMask_q;
        end
`endif
    end

    assign reqElig = bus.req & eligible;

    fft_rr_picker u_picker (
        .req_i    (reqElig[REQ_WB:REQ_FFT]),
        .lastHi_i (lastWb_q),
        .gnt_o    (pickGnt)
    );

    // Only one phase makes any requester eligible, so the concatenation stays one-hot.
    assign gnt = rst ? '0 : {pickGnt, reqElig[REQ_HOST]};

    always_comb begin
        muxAddr = '0;
        muxData = '0;
        muxWe   = 1'b0;
        muxRe   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                muxAddr = muxAddr | bus.addr[i*ADDR_W +: ADDR_W];
                muxData = muxData | bus.wdata[i*DATA_W +: DATA_W];
                muxWe   = muxWe | bus.we[i];
                muxRe   = muxRe | ~bus.we[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HOST;
            busy_q      <= 1'b0;
            lastWb_q    <= 1'b1;
            rvalid_q    <= '0;
`ifdef FFT_ARB_LOCK_EN
            ownerMask_q <= '0;
`endif
        end else begin
            rvalid_q <= gnt & ~bus.we;
            if (gnt[REQ_FFT]) begin
                lastWb_q <= 1'b0;
            end else if (gnt[REQ_WB]) begin
                lastWb_q <= 1'b1;
            end
`ifdef FFT_ARB_LOCK_EN
            if (|gnt) begin
                ownerMask_q <= bus.lock ? gnt : '0;
            end
`endif
            // Any phase change drops ownership; it overrides the grant update above.
            case (state_q)
                HOST: begin
                    if (bus.start) begin
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
`ifdef FFT_ARB_LOCK_EN
                        ownerMask_q <= '0;
`endif
                    end
                end
                DRAIN: begin
                    state_q <= FFT;
                    busy_q  <= 1'b1;
`ifdef FFT_ARB_LOCK_EN
                    ownerMask_q <= '0;
`endif
                end
                FFT: begin
                    if (bus.fft_done) begin
                        state_q <= HOST;
                        busy_q  <= 1'b0;
`ifdef FFT_ARB_LOCK_EN
                        ownerMask_q <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= HOST;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.f_wren    = muxWe;
    assign bus.f_rden    = muxRe;
    assign bus.f_address = muxAddr;
    assign bus.f_data    = muxData;
    assign bus.busy      = busy_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = (|rvalid_q) ? bus.f_q : '0;

endmodule

// File: tb/tb_fft_sram_arbiter.sv
// Directed bench for fft_sram_arbiter with a one-cycle-latency SRAM model.
// Lock scenario runs only when FFT_ARB_LOCK_EN is defined.
module tb_fft_sram_arbiter;

    logic clk;
    logic rst;
    int   vectorCount;
    int   miscompareCount;
`ifdef FFT_ARB_LOCK_EN
    logic lockNext;
`endif

    logic [15:0] mem [0:511];

    fft_sram_arbiter_if #(.ADDR_W(9), .DATA_W(16), .NREQ(3)) bus ();

    fft_sram_arbiter #(.ADDR_W(9), .DATA_W(16), .NREQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: read data appears the cycle after f_rden.
    always @(posedge clk) begin
        if (bus.f_wren) mem[bus.f_address] <= bus.f_data;
        if (bus.f_rden) bus.f_q <= mem[bus.f_address];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] w, input logic [8:0] a,
                                 input logic [15:0] d, input logic s, input logic f);
        @(posedge clk);
        #1;
        bus.req      = r;
        bus.we       = w;
        bus.addr     = {3{a}};
        bus.wdata    = {3{d}};
        bus.start    = s;
        bus.fft_done = f;
`ifdef FFT_ARB_LOCK_EN
        bus.lock     = lockNext;
`endif
        @(negedge clk);
    endtask

    initial begin
        vectorCount     = 0;
        miscompareCount = 0;
        rst          = 1'b1;
        bus.req      = 3'b001;
        bus.we       = 3'b001;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.start    = 1'b0;
        bus.fft_done = 1'b0;
`ifdef FFT_ARB_LOCK_EN
        lockNext     = 1'b0;
        bus.lock     = 1'b0;
`endif
        #3;
        checkOutput("rst_gnt",    32'(bus.gnt), 0);
        checkOutput("rst_wren",   32'(bus.f_wren), 0);
        checkOutput("rst_busy",   32'(bus.busy), 0);
        checkOutput("rst_rvalid", 32'(bus.rvalid), 0);
        checkOutput("rst_rdata",  32'(bus.rdata), 0);
        @(negedge clk);
        rst = 1'b0;

        // Host writes and reads
        applyStimulus(3'b001, 3'b001, 9'h005, 16'h1234, 1'b0, 1'b0);
        checkOutput("host_wr_gnt",  32'(bus.gnt), 1);
        checkOutput("host_wr_wren", 32'(bus.f_wren), 1);
        checkOutput("host_wr_rden", 32'(bus.f_rden), 0);
        checkOutput("host_wr_addr", 32'(bus.f_address), 'h005);
        checkOutput("host_wr_data", 32'(bus.f_data), 'h1234);
        checkOutput("host_wr_busy", 32'(bus.busy), 0);
        applyStimulus(3'b001, 3'b001, 9'h005, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b001, 9'h00A, 16'hCAFE, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b000, 9'h005, 16'h0000, 1'b0, 1'b0);
        checkOutput("host_rd_gnt",  32'(bus.gnt), 1);
        checkOutput("host_rd_rden", 32'(bus.f_rden), 1);
        checkOutput("host_rd_wren", 32'(bus.f_wren), 0);
        applyStimulus(3'b001, 3'b000, 9'h00A, 16'h0000, 1'b0, 1'b0);
        checkOutput("rd_lat_rvalid", 32'(bus.rvalid), 1);
        checkOutput("rd_lat_rdata",  32'(bus.rdata), 'hBEEF);
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
        checkOutput("b2b_rvalid", 32'(bus.rvalid), 1);
        checkOutput("b2b_rdata",  32'(bus.rdata), 'hCAFE);
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
        checkOutput("idle_rvalid", 32'(bus.rvalid), 0);
        checkOutput("idle_rdata",  32'(bus.rdata), 0);
        checkOutput("idle_rden",   32'(bus.f_rden), 0);

        // Phase switch with a read granted in the start cycle
        applyStimulus(3'b001, 3'b000, 9'h005, 16'h0000, 1'b1, 1'b0);
        checkOutput("start_gnt",  32'(bus.gnt), 1);
        checkOutput("start_busy", 32'(bus.busy), 0);
        applyStimulus(3'b011, 3'b000, 9'h00A, 16'h0000, 1'b0, 1'b0);
        checkOutput("drain_busy",   32'(bus.busy), 1);
        checkOutput("drain_gnt",    32'(bus.gnt), 0);
        checkOutput("drain_rden",   32'(bus.f_rden), 0);
        checkOutput("drain_rvalid", 32'(bus.rvalid), 1);
        checkOutput("drain_rdata",  32'(bus.rdata), 'hBEEF);
        applyStimulus(3'b001, 3'b000, 9'h00A, 16'h0000, 1'b1, 1'b0);
        checkOutput("fft_hold_gnt",  32'(bus.gnt), 0);
        checkOutput("fft_hold_busy", 32'(bus.busy), 1);
        applyStimulus(3'b001, 3'b000, 9'h00A, 16'h0000, 1'b0, 1'b1);
        checkOutput("done_gnt",  32'(bus.gnt), 0);
        checkOutput("done_busy", 32'(bus.busy), 1);
        applyStimulus(3'b001, 3'b000, 9'h00A, 16'h0000, 1'b0, 1'b0);
        checkOutput("back_host_gnt",  32'(bus.gnt), 1);
        checkOutput("back_host_busy", 32'(bus.busy), 0);
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
        checkOutput("back_host_rdata", 32'(bus.rdata), 'hCAFE);

        // FFT contention alternates starting with requester 1
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b110, 3'b110, 9'(9'h040 + i), 16'(i), 1'b0, 1'b0);
            checkOutput($sformatf("rr_gnt%0d", i), 32'(bus.gnt), (i % 2 == 0) ? 2 : 4);
        end
        applyStimulus(3'b100, 3'b000, 9'h005, 16'h0000, 1'b0, 1'b0);
        checkOutput("wb_rd_gnt", 32'(bus.gnt), 4);
        applyStimulus(3'b010, 3'b000, 9'h00A, 16'h0000, 1'b0, 1'b1);
        checkOutput("wb_rvalid", 32'(bus.rvalid), 4);
        checkOutput("wb_rdata",  32'(bus.rdata), 'hBEEF);
        checkOutput("fft_rd_gnt", 32'(bus.gnt), 2);
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
        checkOutput("exit_rvalid", 32'(bus.rvalid), 2);
        checkOutput("exit_rdata",  32'(bus.rdata), 'hCAFE);
        checkOutput("exit_busy",   32'(bus.busy), 0);

        // Reset mid-read in FFT phase with requester 1 served last
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b000, 9'h005, 16'h0000, 1'b0, 1'b0);
        checkOutput("pre_rst_gnt", 32'(bus.gnt), 2);
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
        checkOutput("pre_rst_rvalid", 32'(bus.rvalid), 2);
        rst = 1'b1;
        #1;
        checkOutput("midrst_rvalid", 32'(bus.rvalid), 0);
        checkOutput("midrst_rdata",  32'(bus.rdata), 0);
        checkOutput("midrst_busy",   32'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(3'b001, 3'b001, 9'h007, 16'h0777, 1'b0, 1'b0);
        checkOutput("post_rst_gnt",  32'(bus.gnt), 1);
        checkOutput("post_rst_busy", 32'(bus.busy), 0);
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(3'b110, 3'b110, 9'h050, 16'h0000, 1'b0, 1'b0);
        checkOutput("post_rst_ptr_gnt", 32'(bus.gnt), 2);

`ifdef FFT_ARB_LOCK_EN
        // Requester 2 takes ownership and keeps it until it drops lock
        lockNext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b110, 3'b110, 9'h060, 16'h0000, 1'b0, 1'b0);
            checkOutput($sformatf("lock_gnt%0d", i), 32'(bus.gnt), 4);
        end
        lockNext = 1'b0;
        applyStimulus(3'b110, 3'b110, 9'h060, 16'h0000, 1'b0, 1'b0);
        checkOutput("lock_release_gnt", 32'(bus.gnt), 4);
        applyStimulus(3'b110, 3'b110, 9'h060, 16'h0000, 1'b0, 1'b0);
        checkOutput("lock_after_gnt", 32'(bus.gnt), 2);
`endif

        applyStimulus(3'b000, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
